instruction_loader: RTL
=======================

// Module: instruction_loader
// PURPOSE
//  Assembles a byte stream from the debug-unit UART receiver into 32-bit MIPS instruction
//  words and writes them sequentially into instruction memory, starting at word address 0.
//  It is the producer of the instruction stream that fetch/decode later consume.
//  A HALT word (all ones) terminates loading; the HALT word is itself stored.
// PARAMETERS
//  NB_DATA        8             byte width of the UART receive stream
//  NB_INSTRUCTION 32            instruction word width (must equal 4*NB_DATA)
//  NB_ADDR        8             instruction memory word-address width (depth 2**NB_ADDR)
//  HALT_WORD      32'hFFFFFFFF  terminating instruction
// PORTS
//  i_clk           in   1               rising-edge clock
//  i_reset         in   1               synchronous, active-low reset
//  i_start         in   1               one-cycle pulse: begin a new load
//  i_rx_data       in   NB_DATA         received byte
//  i_rx_valid      in   1               i_rx_data valid this cycle (one-cycle pulse per byte)
//  o_wr_en         out  1               instruction memory write strobe
//  o_wr_addr       out  NB_ADDR         word address for o_wr_data
//  o_wr_data       out  NB_INSTRUCTION  assembled instruction
//  o_busy          out  1               high in LOAD state
//  o_done          out  1               high in DONE state (HALT stored)
//  o_overflow      out  1               high in ERROR state (memory full before HALT)
//  o_word_count    out  NB_ADDR+1       words written in current/last load
// BEHAVIOUR
//  - Reset (i_reset==0 at a clock edge): state IDLE; every output 0; byte index 0; address 0.
//    Reset wins over all other inputs and aborts a load mid-word; partial bytes are discarded.
//  - FSM: IDLE -> LOAD on i_start. LOAD -> DONE after HALT written. LOAD -> ERROR on overflow.
//    DONE/ERROR -> LOAD on i_start (restart); they otherwise hold.
//  - i_start in LOAD is ignored. i_start in IDLE/DONE/ERROR clears address, byte index,
//    o_word_count, o_done and o_overflow, then enters LOAD.
//  - Byte order is big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
//  - Bytes are accepted only in LOAD; i_rx_valid in other states is dropped.
//  - 4th byte accepted at edge N: at N the regs load o_wr_data=word, o_wr_addr=current address,
//    o_wr_en=1 for exactly one cycle (latency 1 cycle after 4th-byte valid). Address and
//    o_word_count increment at the same edge. Byte index returns to 0 at the same edge, so a
//    byte arriving in the write-strobe cycle is accepted as byte 0 of the next word.
//  - o_wr_en is 0 in every cycle not following a 4th byte; o_wr_addr/o_wr_data hold last value.
//  - If the word is HALT_WORD: it is written as above and state becomes DONE at the same edge.
//  - Overflow: a completed word while address == 2**NB_ADDR-1 is written (last slot); if that
//    word is not HALT the state becomes ERROR. Address never wraps; no write ever goes to 0
//    again within one load.
//  - o_word_count saturates naturally at 2**NB_ADDR (NB_ADDR+1 bits).
// STRUCTURE
//  - Shared package/header (mips_pkg): HALT_WORD constant, NB_INSTRUCTION, loader state encoding
//    (IDLE=2'd0, LOAD=2'd1, DONE=2'd2, ERROR=2'd3) so the debug unit can decode o_* status.
//  - Single module; natural sub-module: byte_to_word_packer (shift register + 2-bit byte index,
//    outputs word + word_valid); FSM and address counter stay in instruction_loader.
// TESTING
//  - Reset: hold i_reset=0 3 cycles with random i_rx_valid -> all outputs 0, state IDLE.
//  - i_start, bytes 20 08 00 05 -> one o_wr_en pulse, addr 0, data 32'h20080005, count 1.
//  - i_start, two words then FF FF FF FF -> writes at addr 0,1,2 (2 = HALT), o_done=1,
//    o_busy=0, count 3; further bytes produce no o_wr_en.
//  - Back-to-back: 5th byte valid in the write-strobe cycle -> taken as byte 0 of word 2.
//  - NB_ADDR=2: load 4 non-HALT words -> 4 writes (addr 0..3), o_overflow=1, no 5th write.
//  - Reset after 2 bytes of word 1, then i_start + 4 bytes -> single write, addr 0, only new
//    bytes in o_wr_data; i_start during LOAD -> ignored, address continues.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS debug-path definitions: instruction width, HALT terminator and
// loader state encoding so the debug unit can decode loader status directly.
package mips_pkg;

  localparam int NB_DATA        = 8;
  localparam int NB_INSTRUCTION = 32;

  localparam logic [NB_INSTRUCTION-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_e;

endpackage

// File: rtl/byte_to_word_packer.sv
// Big-endian byte-to-word packer: the first three bytes of a word are kept in
// a shift register; the word is presented (with word_valid) in the same cycle
// the fourth byte arrives, and the byte index wraps back to 0 on that edge.
module byte_to_word_packer
  import mips_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_INSTRUCTION = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      byte_valid,
  input  logic [NB_DATA-1:0]        byte_data,
  output logic [NB_INSTRUCTION-1:0] word,
  output logic                      word_valid
);

  localparam int NB_SHIFT = NB_INSTRUCTION - NB_DATA;

  logic [NB_SHIFT-1:0] shift_r;
  logic [1:0]          idx_r;

  assign word       = {shift_r, byte_data};
  assign word_valid = byte_valid && (idx_r == 2'd3);

  // Shift in accepted bytes and track the position within the current word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_r <= {NB_SHIFT{1'b0}};
      idx_r   <= 2'd0;
    end else if (clear) begin
      shift_r <= {NB_SHIFT{1'b0}};
      idx_r   <= 2'd0;
    end else if (byte_valid) begin
      shift_r <= {shift_r[NB_SHIFT-NB_DATA-1:0], byte_data};
      idx_r   <= idx_r + 2'd1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Instruction loader: assembles UART bytes into instruction words and writes
// them to instruction memory from word address 0 until a HALT word is stored
// or the last memory slot has been used.
module instruction_loader
  import mips_pkg::*;
#(
  parameter int                          NB_DATA        = 8,
  parameter int                          NB_INSTRUCTION = 32,
  parameter int                          NB_ADDR        = 8,
  parameter logic [NB_INSTRUCTION-1:0]   HALT_WORD      = 32'hFFFF_FFFF
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NB_DATA-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_wr_en,
  output logic [NB_ADDR-1:0]        o_wr_addr,
  output logic [NB_INSTRUCTION-1:0] o_wr_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow,
  output logic [NB_ADDR:0]          o_word_count
);

  localparam logic [NB_ADDR-1:0] ADDR_LAST = {NB_ADDR{1'b1}};
  localparam logic [NB_ADDR-1:0] ADDR_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0]   COUNT_ONE = {{NB_ADDR{1'b0}}, 1'b1};

  loader_state_e             state_r;
  loader_state_e             state_next_s;
  logic [NB_ADDR-1:0]        addr_r;
  logic [NB_ADDR:0]          count_r;
  logic                      wr_en_r;
  logic [NB_ADDR-1:0]        wr_addr_r;
  logic [NB_INSTRUCTION-1:0] wr_data_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      overflow_r;

  logic                      start_s;
  logic                      accept_s;
  logic [NB_INSTRUCTION-1:0] word_s;
  logic                      word_valid_s;

  // A start only counts outside LOAD; bytes only count inside LOAD.
  assign start_s  = i_start && (state_r != ST_LOAD);
  assign accept_s = i_rx_valid && (state_r == ST_LOAD);

  byte_to_word_packer #(
    .NB_DATA        (NB_DATA),
    .NB_INSTRUCTION (NB_INSTRUCTION)
  ) u_packer (
    .clk        (i_clk),
    .reset      (i_reset),
    .clear      (start_s),
    .byte_valid (accept_s),
    .byte_data  (i_rx_data),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // Next-state logic: HALT ends the load, a full memory without HALT is an error.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (word_valid_s) begin
          if (word_s == HALT_WORD) begin
            state_next_s = ST_DONE;
          end else if (addr_r == ADDR_LAST) begin
            state_next_s = ST_ERROR;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register, registered status flags, write port and address counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_r    <= ST_IDLE;
      addr_r     <= {NB_ADDR{1'b0}};
      count_r    <= {(NB_ADDR+1){1'b0}};
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {NB_ADDR{1'b0}};
      wr_data_r  <= {NB_INSTRUCTION{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      busy_r     <= (state_next_s == ST_LOAD);
      done_r     <= (state_next_s == ST_DONE);
      overflow_r <= (state_next_s == ST_ERROR);
      wr_en_r    <= word_valid_s;
      if (start_s) begin
        addr_r  <= {NB_ADDR{1'b0}};
        count_r <= {(NB_ADDR+1){1'b0}};
      end else if (word_valid_s) begin
        wr_addr_r <= addr_r;
        wr_data_r <= word_s;
        count_r   <= count_r + COUNT_ONE;
        // Hold at the last slot: the load ends there, so the address never wraps.
        if (addr_r != ADDR_LAST) begin
          addr_r <= addr_r + ADDR_ONE;
        end
      end
    end
  end

  assign o_wr_en      = wr_en_r;
  assign o_wr_addr    = wr_addr_r;
  assign o_wr_data    = wr_data_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;
  assign o_overflow   = overflow_r;
  assign o_word_count = count_r;

endmodule
